// File: rtl/ahb_zbt_ctrl.sv
// rtl/ahb_zbt_ctrl.sv - AHB-Lite slave bridging to a pipelined ZBT SSRAM
// One transfer in flight plus one pending address phase; writes drain in four cycles, reads take four.
module ahb_zbt_ctrl (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [1:0]  HSIZE,
  input  logic [31:0] HADDR,
  input  logic [31:0] HWDATA,
  input  logic        HREADYin,
  output logic        HREADYout,
  output logic [31:0] HRDATA,
  output logic [1:0]  HRESP,
  output logic        SCLK,
  output logic [3:0]  SnWBYTE,
  output logic        SnOE,
  output logic        SnCE,
  output logic        SnWR,
  output logic        SADVnLD,
  output logic        SnCKE,
  output logic        SMODE,
  output logic [31:0] SWDATA,
  input  logic [31:0] SRDATA,
  output logic [17:0] SADDR
);

  typedef enum logic [3:0] {
    sIdle, sWData, sWCmd, sWD1, sWD2, sRCmd, sRD1, sRD2, sRDone, sErr1, sErr2
  } stateT;

  stateT       state, nextState;
  logic        pendValid;
  logic [19:0] pendAddr;
  logic [1:0]  pendSize;
  logic        pendWrite;
  logic [3:0]  wByte;
  logic        capture, usePend, dispatch, dispErr, dispWrite, loadPend, clearPend;
  logic [19:0] dispAddr;
  logic [1:0]  dispSize;
  logic        unusedOk;

  function automatic logic badAlign(input logic [1:0] size, input logic [1:0] lsb);
    return (size == 2'b11) || (size == 2'b01 && lsb[0]) || (size == 2'b10 && lsb != 2'b00);
  endfunction

  // Active-low lane enables, little-endian: lane n carries HWDATA[8n+7:8n].
  function automatic logic [3:0] laneMask(input logic [1:0] size, input logic [1:0] lsb);
    case (size)
      2'b00:   laneMask = ~(4'b0001 << lsb);
      2'b01:   laneMask = lsb[1] ? 4'b0011 : 4'b1100;
      default: laneMask = 4'b0000;
    endcase
  endfunction

  assign unusedOk = ^{HADDR[31:20], HTRANS[0]};

  always_comb begin
    HREADYout = 1'b0;
    case (state)
      sIdle, sWData, sRDone, sErr2: HREADYout = 1'b1;
      sWCmd, sWD1, sWD2:            HREADYout = !pendValid;
      default:                      HREADYout = 1'b0;
    endcase
  end

  assign capture   = HSEL & HREADYin & HTRANS[1] & HREADYout;
  assign usePend   = (state == sWD2) & pendValid;
  assign dispAddr  = usePend ? pendAddr  : HADDR[19:0];
  assign dispSize  = usePend ? pendSize  : HSIZE;
  assign dispWrite = usePend ? pendWrite : HWRITE;
  assign dispErr   = badAlign(dispSize, dispAddr[1:0]);

  // While a write drains, a newly accepted address phase parks in the pending slot.
  always_comb begin
    nextState = state;
    dispatch  = 1'b0;
    loadPend  = 1'b0;
    clearPend = 1'b0;
    case (state)
      sIdle, sRDone, sErr2: begin nextState = sIdle;  dispatch = capture; end
      sWData:               begin nextState = sWCmd;  loadPend = capture; end
      sWCmd:                begin nextState = sWD1;   loadPend = capture; end
      sWD1:                 begin nextState = sWD2;   loadPend = capture; end
      sWD2: begin
        nextState = sIdle;
        dispatch  = pendValid | capture;
        clearPend = pendValid;
      end
      sRCmd:   nextState = sRD1;
      sRD1:    nextState = sRD2;
      sRD2:    nextState = sRDone;
      sErr1:   nextState = sErr2;
      default: nextState = sIdle;
    endcase
    if (dispatch)
      nextState = dispErr ? sErr1 : (dispWrite ? sWData : sRCmd);
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state     <= sIdle;
      pendValid <= 1'b0;
      pendAddr  <= '0;
      pendSize  <= '0;
      pendWrite <= 1'b0;
      wByte     <= 4'hF;
      SADDR     <= '0;
      SWDATA    <= '0;
      HRDATA    <= '0;
    end else begin
      state <= nextState;
      if (loadPend) begin
        pendValid <= 1'b1;
        pendAddr  <= HADDR[19:0];
        pendSize  <= HSIZE;
        pendWrite <= HWRITE;
      end else if (clearPend) begin
        pendValid <= 1'b0;
      end
      if (dispatch && !dispErr) begin
        SADDR <= dispAddr[19:2];
        wByte <= laneMask(dispSize, dispAddr[1:0]);
      end
      if (state == sWData) SWDATA <= HWDATA;
      if (state == sRD2)   HRDATA <= SRDATA;
    end
  end

  assign SnCE    = !(state == sRCmd || state == sWCmd);
  assign SnWR    = !(state == sWCmd);
  assign SnOE    = !(state == sRD1 || state == sRD2);
  assign SnWBYTE = (state == sWCmd) ? wByte : 4'hF;
  assign HRESP   = (state == sErr1 || state == sErr2) ? 2'b01 : 2'b00;
  assign SCLK    = HCLK;
  assign SADVnLD = 1'b0;
  assign SnCKE   = 1'b0;
  assign SMODE   = 1'b0;

endmodule

// File: tb/tb_ahb_zbt_ctrl.sv
// tb/tb_ahb_zbt_ctrl.sv - self-checking bench for ahb_zbt_ctrl
// Pipelined AHB master, ZBT SSRAM model and reference memory with a read-data scoreboard.
module tb_ahb_zbt_ctrl;

  logic        HCLK = 1'b0;
  logic        HRESETn, HSEL, HWRITE;
  logic [1:0]  HTRANS, HSIZE;
  logic [31:0] HADDR, HWDATA;
  logic        hreadyBus;
  logic        HREADYout, SCLK, SnOE, SnCE, SnWR, SADVnLD, SnCKE, SMODE;
  logic [31:0] HRDATA, SWDATA;
  logic [31:0] SRDATA = 32'h0;
  logic [1:0]  HRESP;
  logic [3:0]  SnWBYTE;
  logic [17:0] SADDR;

  always #5 HCLK = ~HCLK;
  assign hreadyBus = HREADYout;

  ahb_zbt_ctrl dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HTRANS(HTRANS), .HWRITE(HWRITE),
    .HSIZE(HSIZE), .HADDR(HADDR), .HWDATA(HWDATA), .HREADYin(hreadyBus),
    .HREADYout(HREADYout), .HRDATA(HRDATA), .HRESP(HRESP), .SCLK(SCLK),
    .SnWBYTE(SnWBYTE), .SnOE(SnOE), .SnCE(SnCE), .SnWR(SnWR), .SADVnLD(SADVnLD),
    .SnCKE(SnCKE), .SMODE(SMODE), .SWDATA(SWDATA), .SRDATA(SRDATA), .SADDR(SADDR)
  );

  int total = 0;
  int bad   = 0;

  function automatic logic [31:0] mergeBytes(input logic [31:0] old, input logic [31:0] nw,
                                             input logic [3:0] en);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (en[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  // SSRAM: command at edge Ec, read data driven after Ec+1, write data sampled at Ec+2.
  logic [31:0] sram [0:1023];
  logic        p1Valid = 1'b0, p1Write = 1'b0, p2Valid = 1'b0;
  logic [9:0]  p1Addr = '0, p2Addr = '0;
  logic [3:0]  p1Be = 4'hF, p2Be = 4'hF;

  always @(posedge HCLK) begin
    if (p2Valid) sram[p2Addr] <= mergeBytes(sram[p2Addr], SWDATA, ~p2Be);
    if (p1Valid && !p1Write) SRDATA <= sram[p1Addr];
    p2Valid <= p1Valid && p1Write;
    p2Addr  <= p1Addr;
    p2Be    <= p1Be;
    p1Valid <= (SnCE == 1'b0);
    p1Write <= (SnWR == 1'b0);
    p1Addr  <= SADDR[9:0];
    p1Be    <= SnWBYTE;
  end

  int          ceCnt = 0;
  logic        ceOverlap = 1'b0;
  logic        prevCe = 1'b1;
  logic [17:0] lastWAddr = '0;
  logic [3:0]  lastWByte = 4'hF;

  always @(negedge HCLK) begin
    if (SnCE == 1'b0) begin
      ceCnt <= ceCnt + 1;
      if (prevCe == 1'b0) ceOverlap <= 1'b1;
    end
    prevCe <= SnCE;
    if (SnWR == 1'b0) begin
      lastWAddr <= SADDR;
      lastWByte <= SnWBYTE;
    end
  end

  logic [31:0] refMem [0:1023];
  int          nOps = 0;
  bit          opW   [16];
  logic [1:0]  opSz  [16];
  logic [31:0] opA   [16];
  logic [31:0] opD   [16];
  int          opWait[16];

  typedef struct { int idx; logic [31:0] data; bit err; bit rd; } expT;
  expT sb[$];

  function automatic bit isErr(input logic [1:0] sz, input logic [31:0] a);
    return (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
  endfunction

  function automatic logic [3:0] laneEn(input logic [1:0] sz, input logic [31:0] a);
    logic [3:0] m;
    for (int b = 0; b < 4; b++) begin
      if (sz == 2'b00)      m[b] = (b == int'(a[1:0]));
      else if (sz == 2'b01) m[b] = ((b / 2) == int'(a[1]));
      else                  m[b] = 1'b1;
    end
    return m;
  endfunction

  task automatic addOp(input bit w, input logic [1:0] sz, input logic [31:0] a,
                       input logic [31:0] d, input int wt);
    opW[nOps] = w; opSz[nOps] = sz; opA[nOps] = a; opD[nOps] = d; opWait[nOps] = wt;
    nOps++;
  endtask

  task automatic busIdle();
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HSIZE = 2'b10; HADDR = '0;
  endtask

  task automatic present(input int i);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = opW[i]; HSIZE = opSz[i]; HADDR = opA[i];
  endtask

  task automatic runPipe();
    int  addrIdx = 0, waits = 0, cyc = 0;
    bit  presenting, dataActive = 0, ready, completing, accepting;
    expT e;
    repeat (5) @(posedge HCLK);
    #1 present(0);
    presenting = 1;
    while ((presenting || dataActive) && cyc < 200) begin
      @(negedge HCLK);
      cyc++;
      ready      = HREADYout;
      completing = dataActive && ready;
      accepting  = presenting && ready;
      if (dataActive && !ready) begin
        waits++;
        if (sb[0].err) begin
          total++;
          if (HRESP !== 2'b01) begin
            bad++;
            $display("FAIL err_wait_hresp op%0d got=%b want=01", sb[0].idx, HRESP);
          end
        end
      end
      if (completing) begin
        e = sb.pop_front();
        total++;
        if (HRESP !== (e.err ? 2'b01 : 2'b00)) begin
          bad++;
          $display("FAIL hresp op%0d got=%b want=%b", e.idx, HRESP, e.err ? 2'b01 : 2'b00);
        end
        if (e.rd && !e.err) begin
          total++;
          if (HRDATA !== e.data) begin
            bad++;
            $display("FAIL rdata op%0d got=%h want=%h", e.idx, HRDATA, e.data);
          end
        end
        if (opWait[e.idx] >= 0) begin
          total++;
          if (waits != opWait[e.idx]) begin
            bad++;
            $display("FAIL waits op%0d got=%0d want=%0d", e.idx, waits, opWait[e.idx]);
          end
        end
      end
      if (accepting) begin
        e.idx  = addrIdx;
        e.err  = isErr(opSz[addrIdx], opA[addrIdx]);
        e.rd   = !opW[addrIdx];
        e.data = refMem[opA[addrIdx][11:2]];
        sb.push_back(e);
        if (opW[addrIdx] && !e.err)
          refMem[opA[addrIdx][11:2]] = mergeBytes(refMem[opA[addrIdx][11:2]], opD[addrIdx],
                                                  laneEn(opSz[addrIdx], opA[addrIdx]));
      end
      @(posedge HCLK);
      #1;
      if (completing) dataActive = 0;
      if (accepting) begin
        dataActive = 1;
        waits      = 0;
        HWDATA     = opD[addrIdx];
        addrIdx++;
        presenting = (addrIdx < nOps);
        if (presenting) present(addrIdx);
        else busIdle();
      end
    end
    if (presenting || dataActive) begin
      total++; bad++;
      $display("FAIL pipe_timeout got=%0d cycles want=done", cyc);
    end
    busIdle();
    sb.delete();
    nOps = 0;
    repeat (3) @(posedge HCLK);
    #1;
  endtask

  task automatic test_reset();
    @(negedge HCLK);
    @(negedge HCLK);
    total++;
    if ({HREADYout, HRESP, SnCE, SnWR, SnOE, SnWBYTE} !== 10'b1_00_111_1111) begin
      bad++;
      $display("FAIL reset_ctrl got=%b want=1001111111", {HREADYout, HRESP, SnCE, SnWR, SnOE, SnWBYTE});
    end
    total++;
    if ({HRDATA, SWDATA, SADDR} !== 82'h0) begin
      bad++;
      $display("FAIL reset_data got=%h/%h/%h want=0/0/0", HRDATA, SWDATA, SADDR);
    end
    total++;
    if ({SADVnLD, SnCKE, SMODE, SCLK} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_ties got=%b want=0000", {SADVnLD, SnCKE, SMODE, SCLK});
    end
    HRESETn = 1'b1;
    @(negedge HCLK);
    total++;
    if ({HREADYout, SnCE, HRESP} !== 4'b1100) begin
      bad++;
      $display("FAIL post_reset got=%b want=1100", {HREADYout, SnCE, HRESP});
    end
  endtask

  task automatic test_word();
    addOp(1, 2'b10, 32'h10, 32'hDEADBEEF, 0);
    runPipe();
    addOp(0, 2'b10, 32'h10, 32'h0, 3);
    runPipe();
    total++;
    if (lastWAddr !== 18'h4 || lastWByte !== 4'b0000) begin
      bad++;
      $display("FAIL word_cmd got=%h/%b want=4/0000", lastWAddr, lastWByte);
    end
  endtask

  task automatic test_byte();
    addOp(1, 2'b00, 32'h13, 32'hAA000000, 0);
    runPipe();
    total++;
    if (lastWByte !== 4'b0111) begin
      bad++;
      $display("FAIL byte_lanes got=%b want=0111", lastWByte);
    end
    addOp(0, 2'b10, 32'h10, 32'h0, 3);
    runPipe();
  endtask

  task automatic test_back_to_back();
    int ce0;
    ce0 = ceCnt;
    addOp(1, 2'b10, 32'h20, 32'h11111111, 0);
    addOp(1, 2'b10, 32'h24, 32'h22222222, 3);
    addOp(0, 2'b10, 32'h20, 32'h0, 6);
    addOp(0, 2'b10, 32'h24, 32'h0, 3);
    runPipe();
    total++;
    if (ceCnt - ce0 != 4 || ceOverlap !== 1'b0) begin
      bad++;
      $display("FAIL b2b_ce got=%0d/%b want=4/0", ceCnt - ce0, ceOverlap);
    end
  endtask

  task automatic test_error();
    int ce0;
    ce0 = ceCnt;
    addOp(1, 2'b01, 32'h21, 32'h12345678, 1);
    addOp(0, 2'b10, 32'h20, 32'h0, 3);
    addOp(0, 2'b11, 32'h20, 32'h0, 1);
    addOp(0, 2'b10, 32'h22, 32'h0, 1);
    addOp(1, 2'b01, 32'h22, 32'h5555AAAA, 0);
    addOp(0, 2'b10, 32'h20, 32'h0, 6);
    runPipe();
    total++;
    if (ceCnt - ce0 != 3) begin
      bad++;
      $display("FAIL err_ce got=%0d want=3", ceCnt - ce0);
    end
    total++;
    if (lastWByte !== 4'b0011 || lastWAddr !== 18'h8) begin
      bad++;
      $display("FAIL half_lanes got=%b/%h want=0011/8", lastWByte, lastWAddr);
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    @(posedge HCLK);
    #1 HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HSIZE = 2'b10; HADDR = 32'h24;
    @(posedge HCLK);
    #1 busIdle();
    do begin
      @(negedge HCLK);
      n++;
    end while (SnOE !== 1'b0 && n < 20);
    if (n >= 20) begin
      total++; bad++;
      $display("FAIL rd1_timeout got=%0d want<20", n);
    end
    #2 HRESETn = 1'b0;
    #1;
    total++;
    if ({SnOE, HREADYout, SnCE, HRESP} !== 5'b11100) begin
      bad++;
      $display("FAIL mid_reset_ctrl got=%b want=11100", {SnOE, HREADYout, SnCE, HRESP});
    end
    total++;
    if ({HRDATA, SADDR, SnWBYTE} !== {50'h0, 4'hF}) begin
      bad++;
      $display("FAIL mid_reset_data got=%h/%h/%b want=0/0/1111", HRDATA, SADDR, SnWBYTE);
    end
    @(negedge HCLK);
    HRESETn = 1'b1;
    addOp(0, 2'b10, 32'h24, 32'h0, 3);
    runPipe();
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      sram[i]   = 32'h0;
      refMem[i] = 32'h0;
    end
    HRESETn = 1'b1;
    HWDATA  = 32'h0;
    busIdle();
    #2 HRESETn = 1'b0;
    test_reset();
    test_word();
    test_byte();
    test_back_to_back();
    test_error();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ahb_zbt_ctrl.md
# ahb_zbt_ctrl

AHB-Lite slave that bridges the single-master AHB bus to the external pipelined ZBT SSRAM (slave 2 in the AHB system top). Decodes one AHB transfer at a time, converts it into a ZBT command with two-cycle data latency, inserts wait states on HREADYout, and performs byte-lane writes. Sits between the AHB decoder/mux and the SRAM pins (SRAM_8X4X4096 model in simulation).

## Interface
- No parameters. SRAM depth is fixed at 2^18 words; SADDR = HADDR[19:2].
- HCLK  in  1  system clock.
- HRESETn  in  1  asynchronous, active-low reset.
- HSEL  in  1  slave select from the address decoder.
- HTRANS  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- HWRITE  in  1  1 = write.
- HSIZE  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
- HADDR  in  32  byte address; bits [31:20] ignored.
- HWDATA  in  32  write data, little-endian lanes.
- HREADYin  in  1  bus-level HREADY.
- HREADYout  out  1  slave ready.
- HRDATA  out  32  read data, whole word.
- HRESP  out  2  00 OKAY, 01 ERROR.
- SCLK  out  1  equals HCLK.
- SnWBYTE  out  4  active-low byte write enables; bit n = HWDATA[8n+7:8n].
- SnOE, SnCE, SnWR  out  1 each  active-low output enable, chip enable, write.
- SADVnLD  out  1  tied 0 (load, no bursts).
- SnCKE  out  1  tied 0.
- SMODE  out  1  tied 0.
- SWDATA  out  32  write data to SRAM.
- SRDATA  in  32  read data from SRAM.
- SADDR  out  18  word address.

## Operation
- Capture: address phase is sampled on an HCLK rising edge when HSEL & HREADYin & HTRANS[1] & HREADYout. IDLE/BUSY or unselected transfers get a zero-wait OKAY response.
- Error: HSIZE=11, halfword with HADDR[0]=1, or word with HADDR[1:0]!=0 -> ERR1 (HREADYout=0, HRESP=01), then ERR2 (HREADYout=1, HRESP=01). No SRAM access.
- States: IDLE, WDATA, WCMD, WD1, WD2, RCMD, RD1, RD2, RDONE, ERR1, ERR2.
- Write byte lanes (active low): byte -> only bit HADDR[1:0] low; halfword -> 4'b1100 if HADDR[1]=0, else 4'b0011; word -> 4'b0000.
- Pending slot: one captured address phase (addr, size, write). Captured only while HREADYout=1.
- HREADYout: 1 in IDLE, WDATA, RDONE, ERR2; 0 in RCMD, RD1, RD2, ERR1; in WCMD/WD1/WD2 equals !pend_valid.
- Transitions: IDLE/RDONE/ERR2/WDATA-with-drain-done: on capture go to WDATA (write), RCMD (read) or ERR1. WDATA -> WCMD -> WD1 -> WD2. WD2 -> pending target if pend_valid, else IDLE. RCMD -> RD1 -> RD2 -> RDONE. RDONE -> capture target or IDLE. ERR1 -> ERR2.
- SnCE=0 only in RCMD and WCMD. SnWR=0 only in WCMD. SnOE=0 only in RD1 and RD2. SnWBYTE driven only in WCMD, else 4'hF.
- HRDATA holds its last value until the next read completes. HRESP=00 outside ERR1/ERR2.

## Timing
- Reset values (immediate, asynchronous): state IDLE, pend_valid=0, HREADYout=1, HRESP=00, HRDATA=0, SnCE=1, SnWR=1, SnOE=1, SnWBYTE=4'hF, SADDR=0, SWDATA=0.
- Read captured at edge E0: RCMD E0-E1 (SADDR valid), SRAM samples at E1; SRDATA registered into HRDATA at E3; RDONE E3-E4 with HREADYout=1. The data phase lasts 4 cycles (3 wait states).
- Write captured at E0: WDATA E0-E1 (zero wait), HWDATA registered into SWDATA at E1; command sampled by SRAM at E2; SRAM samples SWDATA at E4. SWDATA holds until the next write capture.
- The earliest next SRAM command is in the cycle starting at E4, so read-after-write to the same address returns new data with no hazard.
- Reset mid-transfer aborts immediately; an in-flight SRAM write may be lost. IDLE is entered after reset release.

## Test plan
- Reset: assert HRESETn=0 mid-cycle -> all outputs at reset values within the same cycle; after release, HREADYout=1 and state IDLE.
- Word write 0x0000_0010 = 0xDEADBEEF, then read 0x10 -> WCMD shows SADDR=0x4 and SnWBYTE=0000; read returns 0xDEADBEEF with HREADYout low for exactly 3 cycles.
- Byte write HADDR=0x13, HWDATA=0xAA000000, then word read 0x10 -> SnWBYTE=4'b0111; read returns 0xAAADBEEF.
- Pipelined write 0x20=0x11111111, write 0x24=0x22222222, read 0x20 -> both writes complete with no overlap of SnCE pulses; HREADYout low while pending; read returns 0x11111111.
- Halfword write to HADDR=0x21 -> HRESP=01 for 2 cycles, HREADYout 0 then 1, SnCE never asserted; next transfer is OKAY.
- HRESETn pulsed low during RD1 -> SnOE=1, HREADYout=1 immediately; a subsequent read completes normally.
